// File: rtl/cdb_wakeup_rs.sv
// Reservation station that snoops a multi-lane CDB tag broadcast to wake source
// operands and issues the oldest fully ready entry through a registered issue port.
module cdb_wakeup_rs #(
    parameter int RS_SIZE         = 4,
    parameter int SUPERSCALAR_WAY = 2,
    parameter int PHY_REG_NUM     = 8,
    localparam int TAG_W = $clog2(PHY_REG_NUM),
    localparam int CNT_W = $clog2(RS_SIZE + 1),
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               dispatch_en_i,
    input  logic [TAG_W-1:0]                   dispatch_dest_i,
    input  logic [TAG_W-1:0]                   dispatch_src1_i,
    input  logic                               dispatch_src1_rdy_i,
    input  logic [TAG_W-1:0]                   dispatch_src2_i,
    input  logic                               dispatch_src2_rdy_i,
    input  logic [SUPERSCALAR_WAY-1:0]         CDB_en_i,
    input  logic [SUPERSCALAR_WAY*TAG_W-1:0]   CDB_i,
    input  logic                               issue_stall_i,
    output logic                               issue_valid_o,
    output logic [TAG_W-1:0]                   issue_dest_o,
    output logic [TAG_W-1:0]                   issue_src1_o,
    output logic [TAG_W-1:0]                   issue_src2_o,
    output logic                               rs_full_o,
    output logic [CNT_W-1:0]                   rs_free_cnt_o
);

    logic [RS_SIZE-1:0]         valid_r;
    logic [RS_SIZE-1:0]         rdy1_r;
    logic [RS_SIZE-1:0]         rdy2_r;
    logic [TAG_W-1:0]           dest_r [RS_SIZE];
    logic [TAG_W-1:0]           src1_r [RS_SIZE];
    logic [TAG_W-1:0]           src2_r [RS_SIZE];
    // Bit (i*RS_SIZE + j) set means entry i is older than entry j.
    logic [RS_SIZE*RS_SIZE-1:0] older_r;

    logic                       issue_valid_r;
    logic [TAG_W-1:0]           issue_dest_r;
    logic [TAG_W-1:0]           issue_src1_r;
    logic [TAG_W-1:0]           issue_src2_r;
    logic                       rs_full_r;
    logic [CNT_W-1:0]           free_cnt_r;

    logic [RS_SIZE-1:0]         ready_s;
    logic                       sel_found_s;
    logic [IDX_W-1:0]           sel_idx_s;
    logic                       free_found_s;
    logic [IDX_W-1:0]           free_idx_s;
    logic                       load_en_s;
    logic                       issue_take_s;
    logic                       disp_acc_s;
    logic [RS_SIZE-1:0]         valid_next_s;
    logic                       byp1_s;
    logic                       byp2_s;

    function automatic logic cdb_hit(
        input logic [TAG_W-1:0]                 tag,
        input logic [SUPERSCALAR_WAY-1:0]       en,
        input logic [SUPERSCALAR_WAY*TAG_W-1:0] bus
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < SUPERSCALAR_WAY; k++) begin
            hit = hit | (en[k] & (bus[k*TAG_W +: TAG_W] == tag));
        end
        return hit;
    endfunction

    function automatic logic is_blocked(
        input int                         idx,
        input logic [RS_SIZE-1:0]         rdy,
        input logic [RS_SIZE*RS_SIZE-1:0] older
    );
        logic blk;
        blk = 1'b0;
        for (int j = 0; j < RS_SIZE; j++) begin
            blk = blk | (rdy[j] & older[j*RS_SIZE + idx]);
        end
        return blk;
    endfunction

    function automatic logic [CNT_W-1:0] pop_count(input logic [RS_SIZE-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

    assign ready_s      = valid_r & rdy1_r & rdy2_r;
    assign load_en_s    = ~issue_valid_r | ~issue_stall_i;
    assign issue_take_s = load_en_s & sel_found_s;
    assign disp_acc_s   = dispatch_en_i & ~rs_full_r & free_found_s;
    assign byp1_s       = dispatch_src1_rdy_i | cdb_hit(dispatch_src1_i, CDB_en_i, CDB_i);
    assign byp2_s       = dispatch_src2_rdy_i | cdb_hit(dispatch_src2_i, CDB_en_i, CDB_i);

    // Oldest-ready select: a ready entry with no older ready entry wins.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {IDX_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_s[i] && !is_blocked(i, ready_s, older_r)) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Lowest-index free slot for dispatch.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {IDX_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Occupancy after this edge: issued slot leaves, dispatched slot arrives.
    always_comb begin
        valid_next_s = valid_r;
        if (issue_take_s) begin
            valid_next_s[sel_idx_s] = 1'b0;
        end else begin
            valid_next_s = valid_next_s;
        end
        if (disp_acc_s) begin
            valid_next_s[free_idx_s] = 1'b1;
        end else begin
            valid_next_s = valid_next_s;
        end
    end

    // Entry storage: wakeup on every entry, dispatch write with bypass, age update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {RS_SIZE{1'b0}};
            rdy1_r  <= {RS_SIZE{1'b0}};
            rdy2_r  <= {RS_SIZE{1'b0}};
            older_r <= {(RS_SIZE*RS_SIZE){1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                dest_r[i] <= {TAG_W{1'b0}};
                src1_r[i] <= {TAG_W{1'b0}};
                src2_r[i] <= {TAG_W{1'b0}};
            end
        end else begin
            valid_r <= valid_next_s;
            for (int i = 0; i < RS_SIZE; i++) begin
                rdy1_r[i] <= rdy1_r[i] | cdb_hit(src1_r[i], CDB_en_i, CDB_i);
                rdy2_r[i] <= rdy2_r[i] | cdb_hit(src2_r[i], CDB_en_i, CDB_i);
            end
            if (disp_acc_s) begin
                dest_r[free_idx_s] <= dispatch_dest_i;
                src1_r[free_idx_s] <= dispatch_src1_i;
                src2_r[free_idx_s] <= dispatch_src2_i;
                rdy1_r[free_idx_s] <= byp1_s;
                rdy2_r[free_idx_s] <= byp2_s;
                // New entry is younger than everyone else.
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_r[int'(free_idx_s)*RS_SIZE + j] <= 1'b0;
                    older_r[j*RS_SIZE + int'(free_idx_s)] <= (j != int'(free_idx_s));
                end
            end else begin
                older_r <= older_r;
            end
        end
    end

    // Issue register: loads the selection unless a valid issue is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid_r <= 1'b0;
            issue_dest_r  <= {TAG_W{1'b0}};
            issue_src1_r  <= {TAG_W{1'b0}};
            issue_src2_r  <= {TAG_W{1'b0}};
        end else if (load_en_s) begin
            if (sel_found_s) begin
                issue_valid_r <= 1'b1;
                issue_dest_r  <= dest_r[sel_idx_s];
                issue_src1_r  <= src1_r[sel_idx_s];
                issue_src2_r  <= src2_r[sel_idx_s];
            end else begin
                issue_valid_r <= 1'b0;
            end
        end else begin
            issue_valid_r <= issue_valid_r;
        end
    end

    // Registered occupancy status derived from next-state occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_cnt_r <= CNT_W'(RS_SIZE);
            rs_full_r  <= 1'b0;
        end else begin
            free_cnt_r <= CNT_W'(RS_SIZE) - pop_count(valid_next_s);
            rs_full_r  <= (pop_count(valid_next_s) == CNT_W'(RS_SIZE));
        end
    end

    assign issue_valid_o = issue_valid_r;
    assign issue_dest_o  = issue_dest_r;
    assign issue_src1_o  = issue_src1_r;
    assign issue_src2_o  = issue_src2_r;
    assign rs_full_o     = rs_full_r;
    assign rs_free_cnt_o = free_cnt_r;

endmodule

// File: tb/tb_cdb_wakeup_rs.sv
// Bench for cdb_wakeup_rs: directed scenarios plus random traffic, checked every
// cycle against an age-ordered queue model of the reservation station.
module tb_cdb_wakeup_rs;

    logic       clk;
    logic       reset_n;
    logic       d_en;
    logic [2:0] d_dest, d_s1, d_s2;
    logic       d_r1, d_r2;
    logic [1:0] cdb_en;
    logic [5:0] cdb;
    logic       stall;
    logic       iv;
    logic [2:0] idest, is1, is2;
    logic       full;
    logic [2:0] free_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] d;
        logic [2:0] s1;
        logic [2:0] s2;
        bit         r1;
        bit         r2;
    } ent_t;

    ent_t       mq[$];
    bit         m_iv;
    logic [2:0] m_d, m_s1, m_s2;

    cdb_wakeup_rs dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .dispatch_en_i       (d_en),
        .dispatch_dest_i     (d_dest),
        .dispatch_src1_i     (d_s1),
        .dispatch_src1_rdy_i (d_r1),
        .dispatch_src2_i     (d_s2),
        .dispatch_src2_rdy_i (d_r2),
        .CDB_en_i            (cdb_en),
        .CDB_i               (cdb),
        .issue_stall_i       (stall),
        .issue_valid_o       (iv),
        .issue_dest_o        (idest),
        .issue_src1_o        (is1),
        .issue_src2_o        (is2),
        .rs_full_o           (full),
        .rs_free_cnt_o       (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [2:0] tag);
        bit h = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (cdb_en[k] && cdb[k*3 +: 3] == tag) h = 1'b1;
        end
        return h;
    endfunction

    // One clock edge of the specified behaviour, applied to the age-ordered queue.
    function automatic void model_step();
        bit load    = !m_iv || !stall;
        bit is_full = (mq.size() == 4);
        int sel     = -1;
        ent_t e;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
                sel = i;
                break;
            end
        end
        if (load) begin
            if (sel >= 0) begin
                m_iv = 1'b1;
                m_d  = mq[sel].d;
                m_s1 = mq[sel].s1;
                m_s2 = mq[sel].s2;
                mq.delete(sel);
            end else begin
                m_iv = 1'b0;
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (hit(mq[i].s1)) mq[i].r1 = 1'b1;
            if (hit(mq[i].s2)) mq[i].r2 = 1'b1;
        end
        if (d_en && !is_full) begin
            e.d  = d_dest;
            e.s1 = d_s1;
            e.s2 = d_s2;
            e.r1 = d_r1 || hit(d_s1);
            e.r2 = d_r2 || hit(d_s2);
            mq.push_back(e);
        end
    endfunction

    task automatic compare();
        chk("issue_valid", int'(iv), int'(m_iv));
        if (m_iv) begin
            chk("issue_dest", int'(idest), int'(m_d));
            chk("issue_src1", int'(is1), int'(m_s1));
            chk("issue_src2", int'(is2), int'(m_s2));
        end
        chk("rs_full", int'(full), int'(mq.size() == 4));
        chk("rs_free_cnt", int'(free_cnt), 4 - mq.size());
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_disp(input logic en, input logic [2:0] dst, input logic [2:0] a,
                            input logic ar, input logic [2:0] b, input logic br);
        d_en = en; d_dest = dst; d_s1 = a; d_r1 = ar; d_s2 = b; d_r2 = br;
    endtask

    task automatic set_cdb(input logic [1:0] en, input logic [2:0] t0, input logic [2:0] t1);
        cdb_en = en;
        cdb    = {t1, t0};
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        set_disp(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        set_cdb(2'b00, 3'd0, 3'd0);
        m_iv = 1'b0; m_d = 3'd0; m_s1 = 3'd0; m_s2 = 3'd0;
        #12;
        reset_n = 1'b1;
        chk("rst_issue_valid", int'(iv), 0);
        chk("rst_issue_dest", int'(idest), 0);
        chk("rst_issue_src1", int'(is1), 0);
        chk("rst_issue_src2", int'(is2), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_free_cnt", int'(free_cnt), 4);

        // Basic wakeup through CDB lane 0
        set_disp(1'b1, 3'd3, 3'd2, 1'b0, 3'd5, 1'b1); step();
        chk("t1_free_after_disp", int'(free_cnt), 3);
        set_disp(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0); step();
        set_cdb(2'b01, 3'd2, 3'd0); step();
        chk("t1_no_same_cycle_issue", int'(iv), 0);
        set_cdb(2'b00, 3'd0, 3'd0); step();
        chk("t1_issue_valid", int'(iv), 1);
        chk("t1_issue_dest", int'(idest), 3);
        chk("t1_issue_src1", int'(is1), 2);
        chk("t1_issue_src2", int'(is2), 5);
        chk("t1_free_back", int'(free_cnt), 4);

        // Dispatch bypass with both lanes
        set_disp(1'b1, 3'd0, 3'd1, 1'b0, 3'd4, 1'b0);
        set_cdb(2'b11, 3'd4, 3'd1); step();
        chk("t2_not_yet", int'(iv), 0);
        set_disp(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        set_cdb(2'b00, 3'd0, 3'd0); step();
        chk("t2_issue_valid", int'(iv), 1);
        chk("t2_issue_dest", int'(idest), 0);

        // Fill, drop a dispatch while full, then drain
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b1, 3'(i + (i / 2) * 2 + 1), 3'd6, 1'b0, 3'd6, 1'b0); step();
        end
        chk("t3_full", int'(full), 1);
        chk("t3_free_zero", int'(free_cnt), 0);
        set_disp(1'b1, 3'd7, 3'd6, 1'b0, 3'd6, 1'b0); step();
        set_disp(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        set_cdb(2'b01, 3'd6, 3'd0); step();
        set_cdb(2'b00, 3'd0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (iv) chk("t3_dropped_never_issues", int'(idest == 3'd7), 0);
        end
        chk("t3_drained", int'(free_cnt), 4);

        // Age order: A older than B, both woken together
        set_disp(1'b1, 3'd2, 3'd3, 1'b0, 3'd3, 1'b0); step();
        set_disp(1'b1, 3'd6, 3'd3, 1'b0, 3'd3, 1'b0); step();
        set_disp(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        set_cdb(2'b10, 3'd0, 3'd3); step();
        set_cdb(2'b00, 3'd0, 3'd0); step();
        chk("t4_older_first", int'(idest), 2);
        step();
        chk("t4_younger_next", int'(idest), 6);
        step();
        chk("t4_empty", int'(iv), 0);

        // Stall holds the issue register
        set_disp(1'b1, 3'd1, 3'd0, 1'b1, 3'd0, 1'b1); step();
        set_disp(1'b1, 3'd5, 3'd0, 1'b1, 3'd0, 1'b1); step();
        chk("t5_first_issued", int'(idest), 1);
        set_disp(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_valid", int'(iv), 1);
            chk("t5_hold_dest", int'(idest), 1);
            chk("t5_hold_free", int'(free_cnt), 3);
        end
        stall = 1'b0; step();
        chk("t5_next_loaded", int'(idest), 5);

        // Reset mid-stream with a held issue
        stall = 1'b1;
        set_disp(1'b1, 3'd4, 3'd7, 1'b0, 3'd7, 1'b0); step();
        chk("t6_pre_valid", int'(iv), 1);
        set_disp(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        stall = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("t6_async_clear", int'(iv), 0);
        chk("t6_async_free", int'(free_cnt), 4);
        mq.delete();
        m_iv = 1'b0;
        #3 reset_n = 1'b1;
        step();
        chk("t6_post_free", int'(free_cnt), 4);
        set_cdb(2'b11, 3'd7, 3'd7); step();
        set_cdb(2'b00, 3'd0, 3'd0); step(); step();
        chk("t6_no_stale", int'(iv), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            set_disp(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                     ($urandom_range(0, 3) == 0), 3'($urandom), ($urandom_range(0, 3) == 0));
            set_cdb(2'($urandom), 3'($urandom), 3'($urandom));
            stall = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
